// File: rtl/gate_reduce_pkg.sv
// Shared mode encoding and default geometry for the gate reduction pipeline.
package gate_reduce_pkg;

    typedef enum logic [1:0] {
        MODE_AND  = 2'd0,
        MODE_OR   = 2'd1,
        MODE_XOR  = 2'd2,
        MODE_NAND = 2'd3
    } mode_e;

    localparam int DEF_NUM_CH = 2;
    localparam int DEF_ROWS   = 3;
    localparam int DEF_COLS   = 4;
    localparam int DEF_CNT_W  = 8;

endpackage

// File: rtl/gate_reduce_pipe_if.sv
// Input/output handshake bundle of gate_reduce_pipe; master is the producer/consumer side.
interface gate_reduce_pipe_if #(
    parameter int NUM_CH = gate_reduce_pkg::DEF_NUM_CH,
    parameter int ROWS   = gate_reduce_pkg::DEF_ROWS,
    parameter int COLS   = gate_reduce_pkg::DEF_COLS,
    parameter int CNT_W  = gate_reduce_pkg::DEF_CNT_W
);
    logic                                    in_valid;
    logic                                    in_ready;
    logic [1:0]                              in_mode;
    logic [NUM_CH-1:0][ROWS-1:0][COLS-1:0]   in_data;
    logic                                    out_valid;
    logic                                    out_ready;
    logic [NUM_CH-1:0]                       out_bit;
    logic [NUM_CH-1:0][ROWS-1:0][COLS-1:0]   out_word;
    logic [NUM_CH-1:0][CNT_W-1:0]            ones_cnt;

    modport master (
        output in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_bit, out_word, ones_cnt
    );

    modport slave (
        input  in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_bit, out_word, ones_cnt
    );
endinterface

// File: rtl/gate_reduce_lane.sv
// Combinational reduction of one channel word under the selected operator.
module gate_reduce_lane
    import gate_reduce_pkg::*;
#(
    parameter int W = DEF_ROWS * DEF_COLS
) (
    input  logic [W-1:0] word,
    input  mode_e        mode,
    output logic         result
);

    always_comb begin
        result = 1'b0;
        unique case (mode)
            MODE_AND:  result = &word;
            MODE_OR:   result = |word;
            MODE_XOR:  result = ^word;
            MODE_NAND: result = ~&word;
        endcase
    end

endmodule

// File: rtl/gate_reduce_pipe.sv
// Two-stage valid/ready pipeline: stage 1 holds word+mode, stage 2 holds per-channel
// reduction bits; also counts output transfers carrying a 1, saturating per channel.
module gate_reduce_pipe
    import gate_reduce_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int ROWS   = DEF_ROWS,
    parameter int COLS   = DEF_COLS,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    gate_reduce_pipe_if.slave bus
);

    localparam int W = ROWS * COLS;

    logic                          s1_v;
    logic [NUM_CH-1:0][W-1:0]      s1_data;
    mode_e                         s1_mode;
    logic                          s2_v;
    logic [NUM_CH-1:0]             s2_bit;
    logic [NUM_CH-1:0]             lane_bit;
    logic [NUM_CH-1:0][CNT_W-1:0]  cnt;
    logic [NUM_CH-1:0][W-1:0]      word_exp;
    logic                          s2_adv;

    // Stage 2 can take new data when empty or when its result leaves this cycle.
    assign s2_adv       = !s2_v || bus.out_ready;
    assign bus.in_ready = !s1_v || s2_adv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v    <= 1'b0;
            s1_data <= '0;
            s1_mode <= MODE_AND;
        end else if (bus.in_ready) begin
            s1_v <= bus.in_valid;
            if (bus.in_valid) begin
                s1_data <= bus.in_data;
                s1_mode <= mode_e'(bus.in_mode);
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        gate_reduce_lane #(.W(W)) u_lane (
            .word   (s1_data[c]),
            .mode   (s1_mode),
            .result (lane_bit[c])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_v   <= 1'b0;
            s2_bit <= '0;
        end else if (s2_adv) begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_bit <= lane_bit;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (s2_v && bus.out_ready) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (s2_bit[c] && (cnt[c] != '1)) begin
                    cnt[c] <= cnt[c] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        word_exp = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            word_exp[c] = {W{s2_bit[c]}};
        end
    end

    assign bus.out_valid = s2_v;
    assign bus.out_bit   = s2_bit;
    assign bus.out_word  = word_exp;
    assign bus.ones_cnt  = cnt;

endmodule

// File: tb/tb_gate_reduce_pipe.sv
// Directed and randomized checks of gate_reduce_pipe, with a second CNT_W=2 instance for saturation.
module tb_gate_reduce_pipe;
    import gate_reduce_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gate_reduce_pipe_if #(.NUM_CH(2), .ROWS(3), .COLS(4), .CNT_W(8)) bus1 ();
    gate_reduce_pipe_if #(.NUM_CH(2), .ROWS(3), .COLS(4), .CNT_W(2)) bus2 ();

    assign bus2.in_valid  = bus1.in_valid;
    assign bus2.in_mode   = bus1.in_mode;
    assign bus2.in_data   = bus1.in_data;
    assign bus2.out_ready = bus1.out_ready;

    gate_reduce_pipe #(.NUM_CH(2), .ROWS(3), .COLS(4), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    gate_reduce_pipe #(.NUM_CH(2), .ROWS(3), .COLS(4), .CNT_W(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [23:0] d);
        bus1.in_valid = v;
        bus1.in_mode  = m;
        bus1.in_data  = d;
    endtask

    function automatic logic [1:0] ref_bits(input logic [23:0] d, input logic [1:0] m);
        logic [1:0] r;
        int ones;
        r = '0;
        for (int c = 0; c < 2; c++) begin
            ones = 0;
            for (int b = 0; b < 12; b++) ones += int'(d[c*12+b]);
            case (m)
                2'd0:    r[c] = (ones == 12);
                2'd1:    r[c] = (ones != 0);
                2'd2:    r[c] = (ones % 2) == 1;
                default: r[c] = (ones != 12);
            endcase
        end
        return r;
    endfunction

    localparam logic [23:0] T1 = {12'h000, 12'h001};
    localparam logic [23:0] T2 = {12'h001, 12'h000};
    localparam logic [23:0] T3 = {12'h001, 12'h001};

    logic [1:0]  q[$];
    logic [1:0]  held_bit, exp_b;
    logic        held, in_fire, out_fire;
    logic [23:0] d;
    int          acc, sel, exp_c0, exp_c1;
    int          sat_tab[8] = '{0, 0, 1, 2, 3, 3, 3, 3};

    initial begin
        drive(1'b0, 2'd0, 24'h0);
        bus1.out_ready = 1'b1;
        #13;
        check_val("rst_out_valid", bus1.out_valid, 0);
        check_val("rst_out_bit", bus1.out_bit, 0);
        check_val("rst_out_word", bus1.out_word, 0);
        check_val("rst_ones_cnt", bus1.ones_cnt, 0);
        check_val("rst_in_ready", bus1.in_ready, 1);

        // First transfer on the first edge after release; AND reduction.
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, MODE_AND, {12'hFFE, 12'hFFF});
        tick();
        check_val("lat_v_early", bus1.out_valid, 0);
        drive(1'b0, 2'd0, 24'h0);
        tick();
        check_val("and_valid", bus1.out_valid, 1);
        check_val("and_bit", bus1.out_bit, 2'b01);
        check_val("and_word", bus1.out_word, {12'h000, 12'hFFF});
        tick();
        check_val("and_drained", bus1.out_valid, 0);
        check_val("and_cnt", bus1.ones_cnt, 16'h0001);

        // Back-to-back mode changes; each result uses its own mode.
        drive(1'b1, MODE_OR, {12'h003, 12'h001});
        tick();
        drive(1'b1, MODE_XOR, {12'h003, 12'h001});
        tick();
        check_val("or_bit", bus1.out_bit, 2'b11);
        drive(1'b1, MODE_NAND, {12'h003, 12'h001});
        tick();
        check_val("xor_bit", bus1.out_bit, 2'b01);
        drive(1'b0, 2'd0, 24'h0);
        tick();
        check_val("nand_valid", bus1.out_valid, 1);
        check_val("nand_bit", bus1.out_bit, 2'b11);
        tick();
        check_val("modes_drained", bus1.out_valid, 0);
        check_val("modes_cnt", bus1.ones_cnt, 16'h0204);

        // Backpressure: only two transactions fit, outputs hold.
        bus1.out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, MODE_OR, (i == 0) ? T1 : (i == 1) ? T2 : T3);
            check_val("bp_in_ready", bus1.in_ready, (i < 2) ? 1 : 0);
            acc += int'(bus1.in_ready);
            tick();
            if (i >= 1) begin
                check_val("bp_hold_valid", bus1.out_valid, 1);
                check_val("bp_hold_bit", bus1.out_bit, 2'b01);
                check_val("bp_hold_word", bus1.out_word, {12'h000, 12'hFFF});
            end
        end
        check_val("bp_accepted", acc, 2);
        drive(1'b0, 2'd0, 24'h0);
        bus1.out_ready = 1'b1;
        #1;
        check_val("bp_ready_release", bus1.in_ready, 1);
        tick();
        check_val("bp_second_valid", bus1.out_valid, 1);
        check_val("bp_second_bit", bus1.out_bit, 2'b10);
        tick();
        check_val("bp_drained", bus1.out_valid, 0);
        check_val("bp_cnt", bus1.ones_cnt, 16'h0305);

        // Async reset with two transactions in flight.
        bus1.out_ready = 1'b0;
        drive(1'b1, MODE_OR, T1);
        tick();
        drive(1'b1, MODE_OR, T2);
        tick();
        drive(1'b0, 2'd0, 24'h0);
        check_val("inflight_valid", bus1.out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_valid", bus1.out_valid, 0);
        check_val("arst_bit", bus1.out_bit, 0);
        check_val("arst_word", bus1.out_word, 0);
        check_val("arst_cnt", bus1.ones_cnt, 0);
        check_val("arst_sat_cnt", bus2.ones_cnt, 0);
        check_val("arst_in_ready", bus1.in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        bus1.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("no_stale", bus1.out_valid, 0);
        end

        // Saturating counter on the CNT_W=2 instance.
        for (int j = 0; j < 8; j++) begin
            drive(j < 5, MODE_OR, T1);
            tick();
            check_val("sat_cnt", bus2.ones_cnt[0], sat_tab[j]);
        end
        check_val("sat_main_cnt", bus1.ones_cnt, 16'h0005);

        // Randomized traffic against a reference queue.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_c0 = 0;
        exp_c1 = 0;
        held = 1'b0;
        held_bit = '0;
        for (int n = 0; n < 10000; n++) begin
            tick();
            if (held) begin
                check_val("hold_valid", bus1.out_valid, 1);
                check_val("hold_bit", bus1.out_bit, held_bit);
            end
            sel = $urandom_range(0, 3);
            if (sel == 0)      d = 24'hFFFFFF;
            else if (sel == 1) d = 24'hFFFFFF ^ (24'h1 << $urandom_range(0, 23));
            else               d = 24'($urandom);
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), d);
            bus1.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            in_fire  = bus1.in_valid && bus1.in_ready;
            out_fire = bus1.out_valid && bus1.out_ready;
            if (out_fire) begin
                if (q.size() == 0) begin
                    check_val("dup_output", 1, 0);
                end else begin
                    exp_b = q.pop_front();
                    check_val("rand_bit", bus1.out_bit, exp_b);
                    check_val("rand_word", bus1.out_word, {{12{exp_b[1]}}, {12{exp_b[0]}}});
                    if (exp_b[0] && exp_c0 < 255) exp_c0++;
                    if (exp_b[1] && exp_c1 < 255) exp_c1++;
                end
            end
            if (in_fire) q.push_back(ref_bits(bus1.in_data, bus1.in_mode));
            held     = bus1.out_valid && !bus1.out_ready;
            held_bit = bus1.out_bit;
        end

        drive(1'b0, 2'd0, 24'h0);
        bus1.out_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (bus1.out_valid) begin
                if (q.size() == 0) begin
                    check_val("dup_drain", 1, 0);
                end else begin
                    exp_b = q.pop_front();
                    check_val("drain_bit", bus1.out_bit, exp_b);
                    if (exp_b[0] && exp_c0 < 255) exp_c0++;
                    if (exp_b[1] && exp_c1 < 255) exp_c1++;
                end
            end
        end
        check_val("lost_txn", q.size(), 0);
        check_val("rand_cnt0", bus1.ones_cnt[0], exp_c0);
        check_val("rand_cnt1", bus1.ones_cnt[1], exp_c1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
